// File: rtl/ex_result_buf.sv
// Two-entry skid buffer between the SIMD adder and writeback.
// Define EX_ZFLAG_EN to add per-lane zero flags (out_zero).
module ex_result_buf #(
    parameter int RD_W   = 5,
    parameter int DATA_W = 64
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [0:DATA_W-1] in_data,
    input  logic [1:0]        in_ww,
    input  logic [RD_W-1:0]   in_rd,
    input  logic              in_wren,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [0:DATA_W-1] out_data,
    output logic [1:0]        out_ww,
    output logic [RD_W-1:0]   out_rd,
`ifdef EX_ZFLAG_EN
    output logic [0:7]        out_zero,
`endif
    output logic              out_wren
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    state_t state;
    state_t next;

    logic valid_q;
    logic ready_q;

    logic              accept_beat;
    logic              release_beat;
    logic              load_main_in;
    logic              load_main_skid;
    logic              load_skid;

    logic [0:DATA_W-1] main_data;
    logic [1:0]        main_ww;
    logic [RD_W-1:0]   main_rd;
    logic              main_wren;
    logic [0:DATA_W-1] skid_data;
    logic [1:0]        skid_ww;
    logic [RD_W-1:0]   skid_rd;
    logic              skid_wren;

    assign accept_beat  = in_valid & ready_q;
    assign release_beat = valid_q & out_ready;

    always_comb begin
        next           = state;
        load_main_in   = 1'b0;
        load_main_skid = 1'b0;
        load_skid      = 1'b0;
        if (flush) begin
            next = EMPTY;
        end else begin
            unique case (state)
                EMPTY: begin
                    if (accept_beat) begin
                        next         = ONE;
                        load_main_in = 1'b1;
                    end
                end
                ONE: begin
                    if (accept_beat && release_beat) begin
                        load_main_in = 1'b1;
                    end else if (accept_beat) begin
                        next      = TWO;
                        load_skid = 1'b1;
                    end else if (release_beat) begin
                        next = EMPTY;
                    end
                end
                TWO: begin
                    if (release_beat) begin
                        next           = ONE;
                        load_main_skid = 1'b1;
                    end
                end
                default: next = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state     <= EMPTY;
            valid_q   <= 1'b0;
            ready_q   <= 1'b1;
            main_data <= '0;
            main_ww   <= '0;
            main_rd   <= '0;
            main_wren <= 1'b0;
            skid_data <= '0;
            skid_ww   <= '0;
            skid_rd   <= '0;
            skid_wren <= 1'b0;
        end else begin
            state   <= next;
            valid_q <= (next != EMPTY);
            ready_q <= (next != TWO);
            if (load_main_in) begin
                main_data <= in_data;
                main_ww   <= in_ww;
                main_rd   <= in_rd;
                main_wren <= in_wren;
            end else if (load_main_skid) begin
                main_data <= skid_data;
                main_ww   <= skid_ww;
                main_rd   <= skid_rd;
                main_wren <= skid_wren;
            end
            if (load_skid) begin
                skid_data <= in_data;
                skid_ww   <= in_ww;
                skid_rd   <= in_rd;
                skid_wren <= in_wren;
            end
        end
    end

`ifdef EX_ZFLAG_EN
    logic [0:7] byte_z;
    logic [0:7] in_zero;
    logic [0:7] main_zero;
    logic [0:7] skid_zero;

    // Lane 0 is the most significant byte; flags replicate across a group.
    always_comb begin
        byte_z  = '0;
        in_zero = '0;
        for (int i = 0; i < 8; i++) begin
            byte_z[i] = (in_data[i*8 +: 8] == 8'h00);
        end
        for (int i = 0; i < 8; i++) begin
            unique case (in_ww)
                2'b00: in_zero[i] = byte_z[i];
                2'b01: in_zero[i] = &byte_z[(i/2)*2 +: 2];
                2'b10: in_zero[i] = &byte_z[(i/4)*4 +: 4];
                2'b11: in_zero[i] = &byte_z;
                default: in_zero[i] = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            main_zero <= '0;
            skid_zero <= '0;
        end else begin
            if (load_main_in) begin
                main_zero <= in_zero;
            end else if (load_main_skid) begin
                main_zero <= skid_zero;
            end
            if (load_skid) begin
                skid_zero <= in_zero;
            end
        end
    end

    assign out_zero = main_zero;
`endif

    assign in_ready  = ready_q;
    assign out_valid = valid_q;
    assign out_data  = main_data;
    assign out_ww    = main_ww;
    assign out_rd    = main_rd;
    assign out_wren  = main_wren;

endmodule

// File: tb/tb_ex_result_buf.sv
// Self-checking bench for ex_result_buf against a queue-based model.
// Zero-flag checks are compiled in when EX_ZFLAG_EN is defined.
module tb_ex_result_buf;

    localparam int RD_W = 5;

    logic            clk = 1'b0;
    logic            reset_n;
    logic            flush;
    logic            in_valid;
    logic            in_ready;
    logic [63:0]     in_data;
    logic [1:0]      in_ww;
    logic [RD_W-1:0] in_rd;
    logic            in_wren;
    logic            out_valid;
    logic            out_ready;
    logic [63:0]     out_data;
    logic [1:0]      out_ww;
    logic [RD_W-1:0] out_rd;
    logic            out_wren;
`ifdef EX_ZFLAG_EN
    logic [7:0]      out_zero;
`endif

    ex_result_buf #(.RD_W(RD_W), .DATA_W(64)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_ww     (in_ww),
        .in_rd     (in_rd),
        .in_wren   (in_wren),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_ww    (out_ww),
        .out_rd    (out_rd),
`ifdef EX_ZFLAG_EN
        .out_zero  (out_zero),
`endif
        .out_wren  (out_wren)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [63:0]     d;
        logic [1:0]      ww;
        logic [RD_W-1:0] rd;
        logic            wren;
    } beat_t;

    beat_t q[$];
    bit    m_ready;
    bit    last_acc;
    bit    last_rst;
    int    checks;
    int    errors;

    // Lane i (i=0 is the top byte) is zero when its whole ww-group is zero.
    function automatic logic [7:0] zflags(logic [63:0] d, logic [1:0] ww);
        logic [7:0] r;
        int g;
        int s;
        g = 1 << ww;
        r = '0;
        for (int i = 0; i < 8; i++) begin
            s = (i / g) * g;
            r[7-i] = 1'b1;
            for (int k = s; k < s + g; k++) begin
                if (d[63-8*k -: 8] != 8'h00) r[7-i] = 1'b0;
            end
        end
        return r;
    endfunction

    function automatic beat_t rand_beat();
        beat_t b;
        for (int k = 0; k < 8; k++) begin
            b.d[8*k +: 8] = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
        end
        b.ww   = 2'($urandom);
        b.rd   = RD_W'($urandom);
        b.wren = 1'($urandom);
        return b;
    endfunction

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic offer(bit v, beat_t b);
        in_valid = v;
        in_data  = b.d;
        in_ww    = b.ww;
        in_rd    = b.rd;
        in_wren  = b.wren;
    endtask

    task automatic cycle();
        bit rel;
        bit acc;
        rel = 1'b0;
        acc = 1'b0;
        if (!reset_n || flush) begin
            q.delete();
        end else begin
            rel = (q.size() > 0) && out_ready;
            acc = in_valid && m_ready;
            if (rel) void'(q.pop_front());
            if (acc) q.push_back(beat_t'{in_data, in_ww, in_rd, in_wren});
        end
        m_ready  = (q.size() < 2);
        last_acc = acc;
        last_rst = !reset_n;
        @(posedge clk);
        #1;
        chk("in_ready", 64'(in_ready), 64'(m_ready));
        chk("out_valid", 64'(out_valid), 64'(q.size() > 0));
        if (q.size() > 0) begin
            chk("out_data", out_data, q[0].d);
            chk("out_ww", 64'(out_ww), 64'(q[0].ww));
            chk("out_rd", 64'(out_rd), 64'(q[0].rd));
            chk("out_wren", 64'(out_wren), 64'(q[0].wren));
`ifdef EX_ZFLAG_EN
            chk("out_zero", 64'(out_zero), 64'(zflags(q[0].d, q[0].ww)));
`endif
        end else if (last_rst) begin
            chk("rst_data", out_data, 64'h0);
            chk("rst_ww", 64'(out_ww), 64'h0);
            chk("rst_rd", 64'(out_rd), 64'h0);
            chk("rst_wren", 64'(out_wren), 64'h0);
`ifdef EX_ZFLAG_EN
            chk("rst_zero", 64'(out_zero), 64'h0);
`endif
        end
    endtask

    beat_t b;
    beat_t idle;
    bit    pend;
    int    tries;

    initial begin
        checks    = 0;
        errors    = 0;
        m_ready   = 1'b1;
        idle      = '0;
        reset_n   = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b0;
        offer(1'b0, idle);
        cycle();
        cycle();
        reset_n = 1'b1;

        // Single beat, one-cycle latency, then empty again
        out_ready = 1'b1;
        offer(1'b1, beat_t'{64'h0102030405060708, 2'b00, 5'd5, 1'b1});
        cycle();
        chk("single_valid", 64'(out_valid), 64'h1);
        chk("single_data", out_data, 64'h0102030405060708);
        chk("single_rd", 64'(out_rd), 64'd5);
        offer(1'b0, idle);
        cycle();
        chk("single_gone", 64'(out_valid), 64'h0);

        // Back-to-back stream
        for (int i = 0; i < 4; i++) begin
            offer(1'b1, rand_beat());
            cycle();
            chk("stream_ready", 64'(in_ready), 64'h1);
        end
        offer(1'b0, idle);
        cycle();
        cycle();

        // Stall: A, B fill the buffer, C is held until space frees
        out_ready = 1'b0;
        offer(1'b1, rand_beat());
        cycle();
        offer(1'b1, rand_beat());
        cycle();
        chk("full_ready", 64'(in_ready), 64'h0);
        offer(1'b1, rand_beat());
        cycle();
        cycle();
        chk("held_not_acc", 64'(last_acc), 64'h0);
        out_ready = 1'b1;
        tries = 0;
        while (!last_acc && tries < 10) begin
            cycle();
            tries++;
        end
        chk("c_accepted", 64'(last_acc), 64'h1);
        offer(1'b0, idle);
        cycle();
        cycle();
        chk("drained", 64'(out_valid), 64'h0);

        // Flush from TWO with a beat offered
        out_ready = 1'b0;
        offer(1'b1, rand_beat());
        cycle();
        cycle();
        flush = 1'b1;
        offer(1'b1, rand_beat());
        cycle();
        flush = 1'b0;
        offer(1'b0, idle);
        chk("flush_valid", 64'(out_valid), 64'h0);
        chk("flush_ready", 64'(in_ready), 64'h1);
        out_ready = 1'b1;
        cycle();
        chk("flush_dropped", 64'(out_valid), 64'h0);

        // Reset mid-transfer
        out_ready = 1'b0;
        offer(1'b1, rand_beat());
        cycle();
        cycle();
        reset_n = 1'b0;
        flush   = 1'b1;
        cycle();
        reset_n = 1'b0;
        flush   = 1'b0;
        chk("rst_mid_data", out_data, 64'h0);
        chk("rst_mid_valid", 64'(out_valid), 64'h0);
        reset_n = 1'b1;
        offer(1'b0, idle);
        cycle();

        // Random traffic with held beats, flushes and rare resets
        pend = 1'b0;
        for (int n = 0; n < 400; n++) begin
            if (!pend && $urandom_range(0, 2) != 0) begin
                b    = rand_beat();
                pend = 1'b1;
            end
            offer(pend, b);
            out_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 29) == 0);
            reset_n   = ($urandom_range(0, 99) != 0);
            cycle();
            if (last_acc || flush || !reset_n) pend = 1'b0;
        end
        flush   = 1'b0;
        reset_n = 1'b1;
        offer(1'b0, idle);
        out_ready = 1'b1;
        cycle();
        cycle();

`ifdef EX_ZFLAG_EN
        offer(1'b1, beat_t'{64'h00FF000000000000, 2'b00, 5'd1, 1'b1});
        cycle();
        chk("zf_byte", 64'(out_zero), 64'(8'b10111111));
        offer(1'b1, beat_t'{64'h00FF000000000000, 2'b01, 5'd2, 1'b1});
        cycle();
        chk("zf_half", 64'(out_zero), 64'(8'b00111111));
        offer(1'b1, beat_t'{64'h00FF000000000000, 2'b11, 5'd3, 1'b1});
        cycle();
        chk("zf_dword", 64'(out_zero), 64'(8'b00000000));
        offer(1'b1, beat_t'{64'h0, 2'b11, 5'd4, 1'b0});
        cycle();
        chk("zf_allzero", 64'(out_zero), 64'(8'b11111111));
        offer(1'b0, idle);
        cycle();
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
